memory: RTL and testbench
=========================

Name: memory

Overview:
- Memory stage of the Beta pipeline. Sits directly downstream of `execute` and consumes its pc_mem_next, ir_mem_next, y_mem_next and st_mem_next.
- Registers those values into the MEM pipeline registers and performs the data-memory access for LD, LDR and ST over a req/ack handshake.
- Holds the upstream pipeline via stall_mem while an access is outstanding, then presents the *_wb_next values to writeback.

Parameters:
- NOP_INST, 32'h83FF_F800, instruction substituted for bubbles: ADD(R31,R31,R31).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ir_src_mem  in  1  `IR_SRC_DATA captures ir_mem_next; `IR_SRC_NOP captures NOP_INST.
- pc_mem_next  in  32  PC from execute.
- ir_mem_next  in  32  instruction from execute.
- y_mem_next  in  32  ALU result; this is the effective address for memory ops.
- st_mem_next  in  32  store data from execute.
- stall_mem  out  1  high means all upstream stages must hold their registers.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write (ST), 0 = read.
- dmem_addr  out  32  access address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid in the ack cycle.
- dmem_ack  in  1  access complete, sampled at posedge.
- misalign  out  1  misaligned memory op flag; see Optional Feature.
- pc_wb_next  out  32  PC to writeback.
- ir_wb_next  out  32  instruction to writeback.
- y_wb_next  out  32  result to writeback: load data for LD/LDR, otherwise the ALU result.

Behaviour:
- Pipe registers: pc_mem, ir_mem, y_mem, st_mem, ld_data, state.
- Capture: at posedge, when stall_mem=0, load pc_mem, y_mem and st_mem from their inputs. ir_mem loads ir_mem_next, or NOP_INST if ir_src_mem=`IR_SRC_NOP.
- Hold: while stall_mem=1, all pipe registers hold.
- Memory op decode on ir[31:26]:
  - `OPCODE_LD (6'h18) and `OPCODE_LDR (6'h1F) are reads.
  - `OPCODE_ST (6'h19) is a write.
- FSM states: IDLE, REQ, DONE.
  - On capture: next state is REQ if the captured instruction is a memory op, else IDLE.
  - REQ: dmem_req=1. When dmem_ack=1 at posedge, latch dmem_rdata into ld_data and go to DONE.
  - DONE: result valid. The next capture reselects REQ or IDLE.
  - A back-to-back memory op goes DONE->REQ with no idle cycle.
- stall_mem = (state==REQ), combinational.
- Request signals in REQ: dmem_addr=y_mem, dmem_wdata=st_mem, dmem_we=(op==ST). These hold stable until ack.
- Request signals outside REQ: dmem_req=0; dmem_addr, dmem_wdata and dmem_we are driven 0.
- dmem_ack while not in REQ is ignored.
- An ack may arrive in the first REQ cycle, giving a minimum 1-cycle stall.
- Writeback outputs are combinational from the pipe registers:
  - pc_wb_next = pc_mem.
  - In REQ, ir_wb_next = NOP_INST (bubble to writeback); otherwise ir_wb_next = ir_mem.
  - y_wb_next = ld_data for LD/LDR in DONE; otherwise y_mem.
- Latency: non-memory ops take 0 extra cycles. Memory ops add (cycles until ack) stall cycles.
- Reset, asynchronous:
  - state=IDLE, ir_mem=NOP_INST.
  - pc_mem, y_mem, st_mem and ld_data are 0.
  - Outputs immediately: stall_mem=0, dmem_req=0, misalign=0.
- Reset mid-access drops dmem_req in the same cycle. The pending access is abandoned, and any ack after reset release is ignored.
- Addresses are passed through unmodified as 32-bit byte addresses; no wrap or sign handling is applied.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- With the macro defined:
  - A captured memory op with y[1:0]!=0 goes straight to DONE and issues no request.
  - misalign=1 while that instruction is in MEM.
  - A misaligned load's y_wb_next = 0.
  - ST writes nothing.
- Without the macro:
  - misalign is tied 0.
  - The address is passed as-is and the access is issued normally.

Test Plan:
- ADD, y_mem_next=32'h5, ir_src_mem=DATA -> next cycle: y_wb_next=5, stall_mem=0, dmem_req never asserted.
- LD, y=32'h100, ack 3 cycles after req with rdata=32'hDEAD_BEEF:
  - stall_mem=1 for exactly 3 cycles and dmem_addr=32'h100, dmem_we=0 throughout.
  - Then y_wb_next=32'hDEADBEEF, with ir_wb_next=NOP_INST while stalled.
- ST, y=32'h40, st=32'h1234, ack in the first REQ cycle -> dmem_we=1, dmem_wdata=32'h1234, stall_mem=1 for 1 cycle. A following LD is captured the next cycle and dmem_req is re-asserted immediately.
- ir_src_mem=`IR_SRC_NOP with ir_mem_next=LD -> ir_wb_next=32'h83FFF800 and no request issued.
- rst pulsed while in REQ -> dmem_req and stall_mem drop without waiting for clk; a later dmem_ack does not change y_wb_next.
- DMEM_ALIGN_CHECK_EN defined: LD with y=32'h102 -> misalign=1, no dmem_req, y_wb_next=0. Undefined: the request is issued to 32'h102.

Source files
------------

// File: rtl/memory.sv
// Memory stage of the Beta pipeline.
// Registers the execute results into the MEM pipe registers, performs the
// LD/LDR/ST data-memory access over a req/ack handshake, and holds the
// upstream pipeline through stall_mem while an access is outstanding.
//
// Handshake: dmem_req is high for every cycle the FSM is in REQ, and
// addr/wdata/we are stable for that whole time. The access completes on the
// rising edge where dmem_ack is high (which may be the first REQ cycle).
// dmem_ack outside REQ is ignored.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When defined, a memory op
// whose address has y[1:0] != 0 raises misalign, issues no request, and a
// misaligned load returns 0.

`ifndef IR_SRC_DATA
`define IR_SRC_DATA 1'b0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 1'b1
`endif

module memory #(
    parameter logic [31:0] NOP_INST = 32'h83FF_F800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_src_mem,
    input  logic [31:0] pc_mem_next,
    input  logic [31:0] ir_mem_next,
    input  logic [31:0] y_mem_next,
    input  logic [31:0] st_mem_next,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        misalign,
    output logic [31:0] pc_wb_next,
    output logic [31:0] ir_wb_next,
    output logic [31:0] y_wb_next
);

    localparam logic [5:0] OPCODE_LD  = 6'h18;
    localparam logic [5:0] OPCODE_ST  = 6'h19;
    localparam logic [5:0] OPCODE_LDR = 6'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_mem_q, pc_mem_d;
    logic [31:0] ir_mem_q, ir_mem_d;
    logic [31:0] y_mem_q, y_mem_d;
    logic [31:0] st_mem_q, st_mem_d;
    logic [31:0] ld_data_q, ld_data_d;

    function automatic logic is_load(input logic [31:0] ir);
        return (ir[31:26] == OPCODE_LD) || (ir[31:26] == OPCODE_LDR);
    endfunction

    function automatic logic is_store(input logic [31:0] ir);
        return ir[31:26] == OPCODE_ST;
    endfunction

    // Address is misaligned only matters when the alignment check is built in.
    function automatic logic is_misaligned(input logic [31:0] ir, input logic [31:0] y);
`ifdef DMEM_ALIGN_CHECK_EN
        return (is_load(ir) || is_store(ir)) && (y[1:0] != 2'b00);
`else
        return 1'b0 & ir[0] & y[0];
`endif
    endfunction

    logic capture;
    logic mem_op_new;
    logic mis_new;
    logic mis_cur;

    // Next-state logic: capture new work when not stalled, else wait for ack.
    always_comb begin
        state_d    = state_q;
        pc_mem_d   = pc_mem_q;
        ir_mem_d   = ir_mem_q;
        y_mem_d    = y_mem_q;
        st_mem_d   = st_mem_q;
        ld_data_d  = ld_data_q;
        capture    = (state_q != REQ);
        mem_op_new = 1'b0;
        mis_new    = 1'b0;

        if (capture) begin
            pc_mem_d   = pc_mem_next;
            y_mem_d    = y_mem_next;
            st_mem_d   = st_mem_next;
            ir_mem_d   = (ir_src_mem == `IR_SRC_NOP) ? NOP_INST : ir_mem_next;
            mem_op_new = is_load(ir_mem_d) || is_store(ir_mem_d);
            mis_new    = is_misaligned(ir_mem_d, y_mem_next);
            if (!mem_op_new) begin
                state_d = IDLE;
            end else if (mis_new) begin
                state_d = DONE;
            end else begin
                state_d = REQ;
            end
        end else if (dmem_ack) begin
            ld_data_d = dmem_rdata;
            state_d   = DONE;
        end
    end

    // Pipe registers and FSM state; reset leaves a bubble in MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_mem_q  <= 32'h0;
            ir_mem_q  <= NOP_INST;
            y_mem_q   <= 32'h0;
            st_mem_q  <= 32'h0;
            ld_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_mem_q  <= pc_mem_d;
            ir_mem_q  <= ir_mem_d;
            y_mem_q   <= y_mem_d;
            st_mem_q  <= st_mem_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Request, stall and writeback outputs, all combinational from the pipe registers.
    always_comb begin
        mis_cur    = is_misaligned(ir_mem_q, y_mem_q);
        stall_mem  = (state_q == REQ);
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        misalign   = mis_cur;
        pc_wb_next = pc_mem_q;
        ir_wb_next = ir_mem_q;
        y_wb_next  = y_mem_q;

        if (state_q == REQ) begin
            dmem_req   = 1'b1;
            dmem_we    = is_store(ir_mem_q);
            dmem_addr  = y_mem_q;
            dmem_wdata = st_mem_q;
            ir_wb_next = NOP_INST;
        end

        if ((state_q == DONE) && is_load(ir_mem_q)) begin
            y_wb_next = mis_cur ? 32'h0 : ld_data_q;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Bench for the Beta MEM stage: directed test-plan steps followed by a
// randomized instruction stream, checked against a word-level memory model.
module tb_memory;

    localparam logic [31:0] NOP   = 32'h83FF_F800;
    localparam logic        SRC_D = 1'b0;
    localparam logic        SRC_N = 1'b1;
    localparam logic [5:0]  OP_LD = 6'h18, OP_ST = 6'h19, OP_LDR = 6'h1F, OP_ADD = 6'h20;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_src_mem;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic        stall_mem, dmem_req, dmem_we, misalign, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next;

    int n_cmp = 0;
    int n_mis = 0;

    // Responder memory (written from the DUT bus) and reference model (written from stimulus).
    logic [31:0] resp_mem  [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] exp_q[$];

    memory dut (
        .clk(clk), .rst(rst), .ir_src_mem(ir_src_mem),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .misalign(misalign),
        .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next), .y_wb_next(y_wb_next)
    );

    // Clock and cycle-budget watchdog.
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction into MEM, serve its access with 'lat' wait cycles,
    // and check the stage behaviour from capture through writeback presentation.
    task automatic do_op(input logic src, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] y, input logic [31:0] st, input int lat,
                         input bit stray_ack);
        logic [31:0] eff_ir;
        logic [5:0]  op;
        bit          is_ld, is_st, mis;
        eff_ir = (src == SRC_N) ? NOP : ir;
        op     = eff_ir[31:26];
        is_ld  = (op == OP_LD) || (op == OP_LDR);
        is_st  = (op == OP_ST);
        mis    = ALIGN_EN && (is_ld || is_st) && (y[1:0] != 2'b00);

        // Reference model: loads see the most recent store to the same address.
        if (is_ld) exp_q.push_back(mis ? 32'h0 : model_read(y));
        else       exp_q.push_back(y);
        if (is_st && !mis) model_mem[y] = st;

        ir_src_mem = src; ir_mem_next = ir; pc_mem_next = pc;
        y_mem_next = y;   st_mem_next = st;
        if (stray_ack) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;

        if ((is_ld || is_st) && !mis) begin
            for (int k = 0; k <= lat; k++) begin
                chk("stall_in_req", {31'b0, stall_mem}, 32'd1);
                chk("req_in_req", {31'b0, dmem_req}, 32'd1);
                chk("addr", dmem_addr, y);
                chk("we", {31'b0, dmem_we}, {31'b0, is_st});
                chk("wdata", dmem_wdata, st);
                chk("ir_wb_bubble", ir_wb_next, NOP);
                if (k == lat) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = resp_mem.exists(dmem_addr) ? resp_mem[dmem_addr] : mem_init(dmem_addr);
                    if (dmem_we) resp_mem[dmem_addr] = dmem_wdata;
                end
                @(posedge clk);
                #1 dmem_ack = 1'b0;
                dmem_rdata = $urandom;
                @(negedge clk);
            end
        end

        chk("stall_after", {31'b0, stall_mem}, 32'd0);
        chk("req_after", {31'b0, dmem_req}, 32'd0);
        chk("addr_idle", dmem_addr, 32'd0);
        chk("misalign", {31'b0, misalign}, {31'b0, mis});
        chk("pc_wb", pc_wb_next, pc);
        chk("ir_wb", ir_wb_next, eff_ir);
        chk("y_wb", y_wb_next, exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] ir_r, y_r;
        int          sel;

        rst = 1'b1; ir_src_mem = SRC_D; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        pc_mem_next = 0; ir_mem_next = 0; y_mem_next = 0; st_mem_next = 0;
        resp_mem[32'h100]  = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;
        #1;
        chk("rst_stall", {31'b0, stall_mem}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_ir_wb", ir_wb_next, NOP);
        chk("rst_pc_wb", pc_wb_next, 32'd0);
        chk("rst_y_wb", y_wb_next, 32'd0);
        #12 rst = 1'b0;
        @(negedge clk);

        // Directed steps from the test plan.
        do_op(SRC_D, {OP_ADD, 26'h0}, 32'h1000, 32'h5, 32'h0, 0, 1'b0);
        do_op(SRC_D, {OP_LD, 26'h0}, 32'h1004, 32'h100, 32'h0, 2, 1'b0);
        do_op(SRC_D, {OP_ST, 26'h0}, 32'h1008, 32'h40, 32'h1234, 0, 1'b0);
        do_op(SRC_D, {OP_LD, 26'h0}, 32'h100C, 32'h40, 32'h0, 1, 1'b0);
        do_op(SRC_N, {OP_LD, 26'h0}, 32'h1010, 32'h80, 32'h0, 0, 1'b0);
        do_op(SRC_D, {OP_LD, 26'h0}, 32'h1014, 32'h102, 32'h0, 0, 1'b0);
        do_op(SRC_D, {OP_LDR, 26'h0}, 32'h1018, 32'h100, 32'h0, 3, 1'b0);

        // Reset while an access is outstanding.
        ir_src_mem = SRC_D; ir_mem_next = {OP_LD, 26'h0}; pc_mem_next = 32'h2000;
        y_mem_next = 32'h8;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_req", {31'b0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", {31'b0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'b0, stall_mem}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ir_mem_next = {OP_ADD, 26'h0}; ir_src_mem = SRC_N; y_mem_next = 32'h0; pc_mem_next = 32'h0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("postrst_y_wb", y_wb_next, 32'd0);
        chk("postrst_req", {31'b0, dmem_req}, 32'd0);
        chk("postrst_ir_wb", ir_wb_next, NOP);

        // Randomized instruction stream over a small address window.
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 3);
            ir_r = {(sel == 0) ? OP_ADD : (sel == 1) ? OP_LD : (sel == 2) ? OP_LDR : OP_ST,
                    26'($urandom)};
            y_r  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) y_r[1:0] = 2'($urandom_range(1, 3));
            do_op(($urandom_range(0, 7) == 0) ? SRC_N : SRC_D, ir_r, $urandom, y_r, $urandom,
                  $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
